// File: rtl/codec_pkg.sv
// codec_pkg: shared constants, stereo sample type and I2S frame builder for the CS4272 interface
// Contents: DATA_W/SLOT_BITS/SCLK_DIV/FRAME_CNT_W constants, stereo_smpl_t, build_frame()
package codec_pkg;
    localparam int DATA_W      = 16;
    localparam int SLOT_BITS   = 32;
    localparam int SCLK_DIV    = 16;
    localparam int SCLK_LOG    = $clog2(SCLK_DIV);
    localparam int FRAME_CNT_W = $clog2(2 * SLOT_BITS * SCLK_DIV);
    localparam int FRAME_W     = 2 * SLOT_BITS;
    localparam int PAD_W       = SLOT_BITS - DATA_W - 1;

    typedef struct packed {
        logic signed [DATA_W-1:0] lft;
        logic signed [DATA_W-1:0] rht;
    } stereo_smpl_t;

    // Leading 0 per slot gives the one-SCLK I2S delay after each LRCLK edge
    function automatic logic [FRAME_W-1:0] build_frame(input stereo_smpl_t s);
        return {1'b0, s.lft, {PAD_W{1'b0}}, 1'b0, s.rht, {PAD_W{1'b0}}};
    endfunction
endpackage

// File: rtl/codec_clk_gen.sv
// codec_clk_gen: free-running frame counter producing MCLK/SCLK/LRCLK and load/shift strobes
// Ports: clk, rst_n (async active-low) in; o_mclk, o_sclk, o_lrclk, o_load_pt, o_shift_pt out
module codec_clk_gen
    import codec_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic o_mclk,
    output logic o_sclk,
    output logic o_lrclk,
    output logic o_load_pt,
    output logic o_shift_pt
);
    logic [FRAME_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= r_cnt + FRAME_CNT_W'(1);
    end

    // Clocks are direct counter bits, so they are glitch-free
    assign o_mclk     = r_cnt[1];
    assign o_sclk     = r_cnt[SCLK_LOG-1];
    assign o_lrclk    = r_cnt[FRAME_CNT_W-1];
    assign o_load_pt  = &r_cnt;
    assign o_shift_pt = &r_cnt[SCLK_LOG-1:0];
endmodule

// File: rtl/codec_i2s_tx.sv
// codec_i2s_tx: stereo sample buffer and I2S serializer driving SDin of the CS4272
// Ports: clk, rst_n (async active-low), lft_in, rht_in, smpl_vld in;
//        smpl_rdy, MCLK, SCLK, LRCLK, SDin, frame_strt, underrun out
// Option: CODEC_TX_UNDERRUN_MUTE_EN makes an underrun frame silent instead of repeating the last pair
module codec_i2s_tx
    import codec_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] lft_in,
    input  logic [DATA_W-1:0] rht_in,
    input  logic              smpl_vld,
    output logic              smpl_rdy,
    output logic              MCLK,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              SDin,
    output logic              frame_strt,
    output logic              underrun
);
    logic               w_load_pt;
    logic               w_shift_pt;
    logic               w_xfer;
    logic               w_bypass;
    logic               w_hold_full_nxt;
    stereo_smpl_t       w_in;
    stereo_smpl_t       w_ld_smpl;
    stereo_smpl_t       r_hold;
    stereo_smpl_t       r_last;
    logic               r_hold_full;
    logic               r_rdy;
    logic [FRAME_W-1:0] r_shreg;

    codec_clk_gen u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .o_mclk     (MCLK),
        .o_sclk     (SCLK),
        .o_lrclk    (LRCLK),
        .o_load_pt  (w_load_pt),
        .o_shift_pt (w_shift_pt)
    );

    assign w_in     = {lft_in, rht_in};
    assign w_xfer   = smpl_vld && r_rdy;
    // Empty buffer with a sample offered on the load cycle goes straight into the frame
    assign w_bypass = !r_hold_full && smpl_vld;
`ifdef CODEC_TX_UNDERRUN_MUTE_EN
    assign w_ld_smpl = r_hold_full ? r_hold : w_bypass ? w_in : '0;
`else
    assign w_ld_smpl = r_hold_full ? r_hold : w_bypass ? w_in : r_last;
`endif
    assign w_hold_full_nxt = w_load_pt ? 1'b0 : (r_hold_full || w_xfer);

    assign smpl_rdy   = r_rdy;
    assign SDin       = r_shreg[FRAME_W-1];
    assign frame_strt = w_load_pt;
    assign underrun   = w_load_pt && !r_hold_full && !smpl_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_full <= 1'b0;
            r_rdy       <= 1'b1;
            r_hold      <= '0;
            r_last      <= '0;
            r_shreg     <= '0;
        end else begin
            r_hold_full <= w_hold_full_nxt;
            r_rdy       <= !w_hold_full_nxt;
            if (w_xfer) r_hold <= w_in;
            if (w_load_pt) begin
                r_last  <= w_ld_smpl;
                r_shreg <= build_frame(w_ld_smpl);
            end else if (w_shift_pt) begin
                r_shreg <= r_shreg << 1;
            end
        end
    end
endmodule
